// File: rtl/op_queue_arb.sv
`default_nettype none
//==============================================================================
// Module   : op_queue_arb
// Desc     : Per-channel op FIFOs merged into one registered head by round-robin.
//            Define OP_QUEUE_DROP_CNT_EN to add saturating per-channel drop counters.
// Revision : 1.0
//==============================================================================
module op_queue_arb #(
   parameter int N_CHANNELS = 2,
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 32,
   localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ce,
   input  logic [N_CHANNELS-1:0]            wr_en,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0] wr_data,
   output logic [N_CHANNELS-1:0]            full,
   input  logic                             rd_en,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic [CH_W-1:0]                  rd_channel,
   output logic                             empty
`ifdef OP_QUEUE_DROP_CNT_EN
   ,
   output logic [N_CHANNELS*8-1:0]          drop_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
   localparam logic [CH_W-1:0]  c_last_ch = CH_W'(N_CHANNELS - 1);

   logic [N_CHANNELS-1:0]                 w_nonempty;
   logic [N_CHANNELS-1:0]                 w_push;
   logic [N_CHANNELS-1:0]                 w_pop;
   logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] w_head;
   logic                                  w_load;
   logic                                  w_found;
   logic [CH_W-1:0]                       w_winner;
   int                                    w_idx;

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [CH_W-1:0]       r_rd_channel;
   logic [CH_W-1:0]       r_last_grant;

   // The head register accepts a new op whenever it is empty or being consumed.
   assign w_load = ce & (~r_valid | rd_en);

   generate
      for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
         logic [DATA_WIDTH-1:0] r_mem [DEPTH];
         logic [PTR_W-1:0]      r_wr_ptr;
         logic [PTR_W-1:0]      r_rd_ptr;
         logic [CNT_W-1:0]      r_count;

         // full comes from the registered count, so a same-cycle pop never frees a slot early.
         assign full[i]       = (r_count == c_depth);
         assign w_nonempty[i] = (r_count != '0);
         assign w_push[i]     = ce & wr_en[i] & ~full[i];
         assign w_pop[i]      = w_load & w_found & (w_winner == CH_W'(i));
         assign w_head[i]     = r_mem[r_rd_ptr];

         always_ff @(posedge clk) begin
            if (w_push[i]) begin
               r_mem[r_wr_ptr] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_push[i]) begin
                  r_wr_ptr <= r_wr_ptr + c_ptr_one;
               end
               if (w_pop[i]) begin
                  r_rd_ptr <= r_rd_ptr + c_ptr_one;
               end
               case ({w_push[i], w_pop[i]})
                  2'b10:   r_count <= r_count + c_cnt_one;
                  2'b01:   r_count <= r_count - c_cnt_one;
                  default: r_count <= r_count;
               endcase
            end
         end

`ifdef OP_QUEUE_DROP_CNT_EN
         logic [7:0] r_drop;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_drop <= 8'd0;
            end else if (ce && wr_en[i] && full[i] && (r_drop != 8'hFF)) begin
               r_drop <= r_drop + 8'd1;
            end
         end

         assign drop_count[i*8 +: 8] = r_drop;
`endif
      end
   endgenerate

   // Round-robin: scan from the channel after the last grant, first non-empty wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = 1; k <= N_CHANNELS; k++) begin
         w_idx = int'(r_last_grant) + k;
         if (w_idx >= N_CHANNELS) begin
            w_idx = w_idx - N_CHANNELS;
         end
         for (int j = 0; j < N_CHANNELS; j++) begin
            if (!w_found && (j == w_idx) && w_nonempty[j]) begin
               w_found  = 1'b1;
               w_winner = CH_W'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_rd_data    <= '0;
         r_rd_channel <= '0;
         r_last_grant <= c_last_ch;
      end else if (w_load) begin
         r_valid <= w_found;
         if (w_found) begin
            r_rd_data    <= w_head[w_winner];
            r_rd_channel <= w_winner;
            r_last_grant <= w_winner;
         end
      end
   end

   assign rd_data    = r_rd_data;
   assign rd_channel = r_rd_channel;
   assign empty      = ~r_valid;

endmodule
`default_nettype wire

// File: tb/tb_op_queue_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_op_queue_arb
// Desc     : Directed vector bench for op_queue_arb (3 channels, depth 4, 8-bit ops).
// Revision : 1.0
//==============================================================================
module tb_op_queue_arb;

   localparam int N_CH = 3;
   localparam int DEP  = 4;
   localparam int DW   = 8;
   localparam int NVEC = 28;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [2:0]    wr_en;
   logic [23:0]   wr_data;
   logic [2:0]    full;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic [1:0]    rd_channel;
   logic          empty;
`ifdef OP_QUEUE_DROP_CNT_EN
   logic [23:0]   drop_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  we;
      logic [23:0] wd;
      logic        re;
      logic [2:0]  e_full;
      logic        e_empty;
      logic [7:0]  e_data;
      logic [1:0]  e_ch;
   } vec_t;

   vec_t tbl [NVEC];

   op_queue_arb #(
      .N_CHANNELS (N_CH),
      .DEPTH      (DEP),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_channel (rd_channel),
      .empty      (empty)
`ifdef OP_QUEUE_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic [2:0] we, input logic [23:0] wd, input logic re);
      ce      = c;
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string name, input logic e_empty, input logic [7:0] e_data,
                             input logic [1:0] e_ch, input logic [2:0] e_full);
      check({name, " empty"}, empty, e_empty);
      check({name, " full"}, full, e_full);
      if (!e_empty) begin
         check({name, " data"}, rd_data, e_data);
         check({name, " chan"}, rd_channel, e_ch);
      end
   endtask

   initial begin
      // three channels pushing together, drained round-robin from channel 0
      tbl[0]  = '{3'b111, 24'h302010, 1'b1, 3'b000, 1'b1, 8'h00, 2'd0};
      tbl[1]  = '{3'b111, 24'h312111, 1'b1, 3'b000, 1'b0, 8'h10, 2'd0};
      tbl[2]  = '{3'b111, 24'h322212, 1'b1, 3'b000, 1'b0, 8'h20, 2'd1};
      tbl[3]  = '{3'b111, 24'h332313, 1'b1, 3'b000, 1'b0, 8'h30, 2'd2};
      tbl[4]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h11, 2'd0};
      tbl[5]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h21, 2'd1};
      tbl[6]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h31, 2'd2};
      tbl[7]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h12, 2'd0};
      tbl[8]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h22, 2'd1};
      tbl[9]  = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h32, 2'd2};
      tbl[10] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h13, 2'd0};
      tbl[11] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h23, 2'd1};
      tbl[12] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h33, 2'd2};
      tbl[13] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b1, 8'h00, 2'd0};
      // single push latency: queued at edge t, presented after edge t+1
      tbl[14] = '{3'b001, 24'h0000A1, 1'b0, 3'b000, 1'b1, 8'h00, 2'd0};
      tbl[15] = '{3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 8'hA1, 2'd0};
      tbl[16] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b1, 8'h00, 2'd0};
      // fill ch1 behind a held head; 5th push and push-during-pop on full are dropped
      tbl[17] = '{3'b001, 24'h000077, 1'b0, 3'b000, 1'b1, 8'h00, 2'd0};
      tbl[18] = '{3'b010, 24'h004100, 1'b0, 3'b000, 1'b0, 8'h77, 2'd0};
      tbl[19] = '{3'b010, 24'h004200, 1'b0, 3'b000, 1'b0, 8'h77, 2'd0};
      tbl[20] = '{3'b010, 24'h004300, 1'b0, 3'b000, 1'b0, 8'h77, 2'd0};
      tbl[21] = '{3'b010, 24'h004400, 1'b0, 3'b010, 1'b0, 8'h77, 2'd0};
      tbl[22] = '{3'b010, 24'h004500, 1'b0, 3'b010, 1'b0, 8'h77, 2'd0};
      tbl[23] = '{3'b010, 24'h004600, 1'b1, 3'b000, 1'b0, 8'h41, 2'd1};
      tbl[24] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h42, 2'd1};
      tbl[25] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h43, 2'd1};
      tbl[26] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 8'h44, 2'd1};
      tbl[27] = '{3'b000, 24'h000000, 1'b1, 3'b000, 1'b1, 8'h00, 2'd0};

      rst = 1'b1;
      drive(1'b1, 3'b000, 24'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset empty", empty, 1'b1);
      check("reset full", full, 3'b000);
      check("reset data", rd_data, 8'h00);
      check("reset chan", rd_channel, 2'd0);
      rst = 1'b0;

      for (int k = 0; k < NVEC; k++) begin
         drive(1'b1, tbl[k].we, tbl[k].wd, tbl[k].re);
         tick;
         check_head($sformatf("vec%0d", k), tbl[k].e_empty, tbl[k].e_data, tbl[k].e_ch, tbl[k].e_full);
      end
`ifdef OP_QUEUE_DROP_CNT_EN
      check("drop ch1", drop_count[15:8], 8'd2);
      check("drop ch0", drop_count[7:0], 8'd0);
`endif

      // clock enable low: head and queues must stay put despite toggling requests
      drive(1'b1, 3'b101, 24'h620061, 1'b0);
      tick;
      check_head("ce pre0", 1'b1, 8'h00, 2'd0, 3'b000);
      drive(1'b1, 3'b000, 24'h0, 1'b0);
      tick;
      check_head("ce pre1", 1'b0, 8'h62, 2'd2, 3'b000);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, (k % 2 == 1) ? 3'b111 : 3'b010, 24'hEEDDCC, (k % 2 == 0));
         tick;
         check_head($sformatf("ce off%0d", k), 1'b0, 8'h62, 2'd2, 3'b000);
      end
      drive(1'b1, 3'b000, 24'h0, 1'b1);
      tick;
      check_head("ce post0", 1'b0, 8'h61, 2'd0, 3'b000);
      tick;
      check_head("ce post1", 1'b1, 8'h00, 2'd0, 3'b000);

      // asynchronous reset in the middle of traffic
      drive(1'b1, 3'b011, 24'h00B0A0, 1'b0);
      tick;
      check_head("rst q0", 1'b1, 8'h00, 2'd0, 3'b000);
      drive(1'b1, 3'b011, 24'h00B1A1, 1'b0);
      tick;
      check_head("rst q1", 1'b0, 8'hB0, 2'd1, 3'b000);
      drive(1'b1, 3'b001, 24'h0000A2, 1'b0);
      tick;
      drive(1'b1, 3'b001, 24'h0000A3, 1'b0);
      tick;
      check_head("rst q3", 1'b0, 8'hB0, 2'd1, 3'b001);
      drive(1'b1, 3'b000, 24'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async rst empty", empty, 1'b1);
      check("async rst full", full, 3'b000);
      check("async rst data", rd_data, 8'h00);
`ifdef OP_QUEUE_DROP_CNT_EN
      check("async rst drop", drop_count, 24'h0);
`endif
      #1 rst = 1'b0;
      drive(1'b1, 3'b010, 24'h005500, 1'b0);
      tick;
      check_head("post rst0", 1'b1, 8'h00, 2'd0, 3'b000);
      drive(1'b1, 3'b000, 24'h0, 1'b0);
      tick;
      check_head("post rst1", 1'b0, 8'h55, 2'd1, 3'b000);
      drive(1'b1, 3'b000, 24'h0, 1'b1);
      tick;
      check_head("post rst2", 1'b1, 8'h00, 2'd0, 3'b000);

      // 300 pushes into ch0 with no reads: head takes 1, queue 4, rest dropped
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 3'b001, {16'h0, 8'(k + 1)}, 1'b0);
         tick;
      end
      check_head("sat head", 1'b0, 8'h01, 2'd0, 3'b001);
`ifdef OP_QUEUE_DROP_CNT_EN
      check("sat drop ch0", drop_count[7:0], 8'hFF);
`endif
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 3'b000, 24'h0, 1'b1);
         tick;
         check_head($sformatf("sat pop%0d", k), 1'b0, 8'(k + 2), 2'd0, 3'b000);
      end
      drive(1'b1, 3'b000, 24'h0, 1'b1);
      tick;
      check_head("sat drained", 1'b1, 8'h00, 2'd0, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
